regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: ZERO_WRITABLE, default 0, when 0 writes targeting register 0 are accepted but never asserted to the register file.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset; takes effect only on a rising clk edge.
REQ-004 Port: a_valid  input  1  ALU writeback request.
REQ-005 Port: a_reg, a_data  input  5, 32  ALU destination register and result.
REQ-006 Port: a_ready  output  1  ALU request accepted this cycle (combinational).
REQ-007 Port: b_valid  input  1  load writeback request.
REQ-008 Port: b_reg, b_data  input  5, 32  load destination register and data.
REQ-009 Port: b_ready  output  1  load request accepted this cycle (combinational).
REQ-010 Port: rsv_valid, rsv_reg  input  1, 5  issue stage reserves a destination register.
REQ-011 Port: read_reg1, read_reg2  input  5, 5  source registers of the instruction being issued.
REQ-012 Port: stall  output  1  a source register has an outstanding write (combinational).
REQ-013 Port: write_reg  output  5  registered register-file write address.
REQ-014 Port: reg_write_flag  output  1  registered register-file write enable.
REQ-015 Port: data  output  32  registered register-file write data.
REQ-016 Port: busy  output  32  scoreboard; bit r = register r has an outstanding write.

Function
REQ-017 Handshake: a request transfers in the cycle where valid and ready are both 1; valid SHALL remain asserted with stable reg/data until transfer.
REQ-018 Arbitration: at most one of a_ready/b_ready SHALL be 1 per cycle; ready never asserted without matching valid.
REQ-019 Only one valid -> that requester gets ready in the same cycle.
REQ-020 Both valid -> winner is given by a 1-bit round-robin pointer (0 = A, 1 = B); after such a grant the pointer SHALL point to the loser.
REQ-021 Pointer SHALL NOT change on cycles with zero or one valid requester.
REQ-022 Latency: a transfer in cycle N SHALL appear on write_reg/data in cycle N+1 with reg_write_flag = 1, unless target is register 0 and ZERO_WRITABLE = 0 (then reg_write_flag = 0, write_reg/data still loaded).
REQ-023 No transfer in cycle N -> reg_write_flag = 0 in cycle N+1; write_reg and data hold their previous values.
REQ-024 Throughput: one transfer per cycle sustained; no bubbles when requesters stay valid.
REQ-025 Scoreboard set: rsv_valid = 1 with rsv_reg = r != 0 sets busy[r] at the next edge; reservation of register 0 is ignored.
REQ-026 Scoreboard clear: busy[write_reg] clears at the edge ending a cycle with reg_write_flag = 1.
REQ-027 Simultaneous set and clear of the same register at one edge -> set wins (busy stays 1).
REQ-028 Reservation of an already-busy register SHALL leave it busy (no counting; single outstanding producer per register).
REQ-029 stall = busy[read_reg1] | busy[read_reg2], evaluated combinationally on current busy; busy[0] is constant 0.
REQ-030 A write that is dropped per REQ-022 SHALL NOT clear any busy bit.

Reset
REQ-031 rst = 1 at an edge SHALL clear busy to 0, reg_write_flag to 0, write_reg to 0, data to 0, pointer to 0 (A).
REQ-032 During a rst cycle requests may see ready = 1 combinationally but the transfer SHALL be discarded; reset wins over any transfer or reservation at that edge.
REQ-033 Reset mid-operation SHALL lose all outstanding reservations and any in-flight write without asserting reg_write_flag on the following cycle.

Verification
REQ-034 Single A: a_valid=1, a_reg=5, a_data=0xDEADBEEF at cycle N -> a_ready=1 in N; cycle N+1 write_reg=5, data=0xDEADBEEF, reg_write_flag=1.
REQ-035 Contention: A and B valid for 4 cycles after reset -> grants A,B,A,B; four consecutive reg_write_flag pulses in that order.
REQ-036 Register 0: b_valid=1, b_reg=0, b_data=0x1234 -> b_ready=1, next cycle reg_write_flag=0, data=0x1234, busy unchanged.
REQ-037 Scoreboard: reserve reg 7, then read_reg1=7 -> stall=1; A writes reg 7 -> stall=1 through the reg_write_flag cycle, stall=0 the cycle after.
REQ-038 Set/clear collision: reg_write_flag=1 for reg 9 while rsv_valid=1, rsv_reg=9 -> busy[9]=1 after the edge.
REQ-039 Reset mid-stream: busy=0x0000_0084, A transfer in same cycle as rst=1 -> next cycle busy=0, reg_write_flag=0, pointer=A.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Merges two writeback sources (ALU = A, load = B) into the single register
//   file write port. It also keeps a per-register scoreboard of outstanding
//   writes so that the issue stage can stall on source operands.
//
// Parameters
//   ZERO_WRITABLE  : 0 -> writes to register 0 are accepted but never enabled
//
// Ports
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   a_valid/a_reg/a_data     : ALU writeback request, a_ready = accepted
//   b_valid/b_reg/b_data     : load writeback request, b_ready = accepted
//   rsv_valid/rsv_reg        : issue stage reserves a destination register
//   read_reg1/read_reg2      : source registers of the issuing instruction
//   stall                    : a source register has an outstanding write
//   write_reg/data           : registered register-file write address/data
//   reg_write_flag           : registered register-file write enable
//   busy                     : scoreboard, bit r = register r outstanding
module regfile_wb_arbiter #(
  parameter int ZERO_WRITABLE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_reg,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic        stall,
  output logic [4:0]  write_reg,
  output logic        reg_write_flag,
  output logic [31:0] data,
  output logic [31:0] busy
);

  // Round-robin pointer: 0 = A has priority, 1 = B has priority.
  logic        ptr_q, ptr_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_flag_q, reg_write_flag_d;
  logic [31:0] data_q, data_d;
  logic [31:0] busy_q, busy_d;

  logic        xfer_s;
  logic [4:0]  xfer_reg_s;
  logic [31:0] xfer_data_s;

  // Grant selection: a lone requester always wins, contention follows ptr_q.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (a_valid && b_valid) begin
      a_ready = ~ptr_q;
      b_ready = ptr_q;
    end else begin
      a_ready = a_valid;
      b_ready = b_valid;
    end
  end

  // Transfer mux and next-state computation for the write port and pointer.
  always_comb begin
    xfer_s      = a_ready | b_ready;
    xfer_reg_s  = 5'd0;
    xfer_data_s = 32'd0;
    if (b_ready) begin
      xfer_reg_s  = b_reg;
      xfer_data_s = b_data;
    end else begin
      xfer_reg_s  = a_reg;
      xfer_data_s = a_data;
    end

    // After a contended grant the pointer moves to the loser.
    if (a_valid && b_valid) begin
      ptr_d = ~ptr_q;
    end else begin
      ptr_d = ptr_q;
    end

    // Address and data hold when idle; the enable pulses only for real writes.
    if (xfer_s) begin
      write_reg_d      = xfer_reg_s;
      data_d           = xfer_data_s;
      reg_write_flag_d = (ZERO_WRITABLE != 0) || (xfer_reg_s != 5'd0);
    end else begin
      write_reg_d      = write_reg_q;
      data_d           = data_q;
      reg_write_flag_d = 1'b0;
    end
  end

  // Scoreboard update: clear on completed write first, so a reservation of
  // the same register at the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_flag_q) begin
      busy_d[write_reg_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (rsv_valid && (rsv_reg != 5'd0)) begin
      busy_d[rsv_reg] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; reset discards any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q            <= 1'b0;
      write_reg_q      <= 5'd0;
      reg_write_flag_q <= 1'b0;
      data_q           <= 32'd0;
      busy_q           <= 32'd0;
    end else begin
      ptr_q            <= ptr_d;
      write_reg_q      <= write_reg_d;
      reg_write_flag_q <= reg_write_flag_d;
      data_q           <= data_d;
      busy_q           <= busy_d;
    end
  end

  // Operand hazard detection on the current scoreboard.
  always_comb begin
    stall = busy_q[read_reg1] | busy_q[read_reg2];
  end

  assign write_reg      = write_reg_q;
  assign reg_write_flag = reg_write_flag_q;
  assign data           = data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, rsv_valid;
  logic [4:0]  a_reg, b_reg, rsv_reg, read_reg1, read_reg2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, stall, reg_write_flag;
  logic [4:0]  write_reg;
  logic [31:0] data, busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ZERO_WRITABLE(0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .stall(stall),
    .write_reg(write_reg), .reg_write_flag(reg_write_flag), .data(data),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ptr;            // who wins the next contention: 0=A, 1=B
  bit          m_busy [32];      // outstanding-write set
  bit [4:0]    m_wr;
  bit [31:0]   m_data;
  bit          m_flag;

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 1'b0; m_wr = 5'd0; m_data = 32'd0; m_flag = 1'b0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic model_grant(output bit ga, output bit gb);
    if (a_valid && b_valid) begin
      ga = (m_ptr == 1'b0);
      gb = (m_ptr == 1'b1);
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    bit ga, gb;
    model_grant(ga, gb);
    if (rst) begin
      model_reset();
    end else begin
      if (m_flag) m_busy[m_wr] = 1'b0;
      if (rsv_valid && rsv_reg != 5'd0) m_busy[rsv_reg] = 1'b1;
      if (a_valid && b_valid) m_ptr = !m_ptr;
      if (ga) begin
        m_wr = a_reg; m_data = a_data; m_flag = (a_reg != 5'd0);
      end else if (gb) begin
        m_wr = b_reg; m_data = b_data; m_flag = (b_reg != 5'd0);
      end else begin
        m_flag = 1'b0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic bv; logic [4:0] br; logic [31:0] bd;
    logic rv; logic [4:0] rr;
    logic [4:0] r1; logic [4:0] r2;
    logic e_ar; logic e_br; logic e_st;
    logic [4:0] e_wr; logic e_fl; logic [31:0] e_d; logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic bv, input logic [4:0] br, input logic [31:0] bd,
    input logic rv, input logic [4:0] rr, input logic [4:0] r1, input logic [4:0] r2,
    input logic e_ar, input logic e_br, input logic e_st,
    input logic [4:0] e_wr, input logic e_fl, input logic [31:0] e_d, input logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.rv = rv; v.rr = rr; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_br = e_br; v.e_st = e_st;
    v.e_wr = e_wr; v.e_fl = e_fl; v.e_d = e_d; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t vt [12];

  task automatic drive_idle();
    a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
    rsv_valid = 1'b0; rsv_reg = 5'd0; read_reg1 = 5'd0; read_reg2 = 5'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Set both requests at once (used by the hand-written sequences).
  task automatic drive_ab(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  initial begin
    bit ga, gb, mst;
    bit a_pend, b_pend;
    logic [4:0] exp_wr [4];

    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    do_reset();
    check("reset_flag", {31'd0, reg_write_flag}, 32'd0);
    check("reset_wr", {27'd0, write_reg}, 32'd0);
    check("reset_data", data, 32'd0);
    check("reset_busy", busy, 32'd0);

    //            av   ar     ad            bv   br     bd            rv   rr     r1     r2     ar   br   st   wr     fl   d             busy
    vt[0]  = mk(1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,       1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0, 5'd5,1'b1,32'hDEADBEEF,32'h0);
    vt[1]  = mk(1'b1,5'd3,32'h11111111, 1'b1,5'd4,32'h22222222, 1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0, 5'd3,1'b1,32'h11111111,32'h0);
    vt[2]  = mk(1'b1,5'd6,32'h33333333, 1'b1,5'd4,32'h22222222, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0, 5'd4,1'b1,32'h22222222,32'h0);
    vt[3]  = mk(1'b1,5'd6,32'h33333333, 1'b0,5'd0,32'h0,       1'b1,5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0, 5'd6,1'b1,32'h33333333,32'h80);
    vt[4]  = mk(1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd0, 5'd7, 5'd0, 1'b0,1'b0,1'b1, 5'd6,1'b0,32'h33333333,32'h80);
    vt[5]  = mk(1'b0,5'd0,32'h0,       1'b1,5'd0,32'h1234,    1'b0,5'd0, 5'd7, 5'd0, 1'b0,1'b1,1'b1, 5'd0,1'b0,32'h1234,    32'h80);
    vt[6]  = mk(1'b1,5'd7,32'hCAFEF00D, 1'b0,5'd0,32'h0,       1'b1,5'd9, 5'd0, 5'd7, 1'b1,1'b0,1'b1, 5'd7,1'b1,32'hCAFEF00D,32'h280);
    vt[7]  = mk(1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd0, 5'd7, 5'd9, 1'b0,1'b0,1'b1, 5'd7,1'b0,32'hCAFEF00D,32'h200);
    vt[8]  = mk(1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd0, 5'd7, 5'd0, 1'b0,1'b0,1'b0, 5'd7,1'b0,32'hCAFEF00D,32'h200);
    vt[9]  = mk(1'b1,5'd9,32'h99,      1'b0,5'd0,32'h0,       1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b1, 5'd9,1'b1,32'h99,      32'h200);
    vt[10] = mk(1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b1,5'd9, 5'd9, 5'd0, 1'b0,1'b0,1'b1, 5'd9,1'b0,32'h99,      32'h200);
    vt[11] = mk(1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd0, 5'd9, 5'd0, 1'b0,1'b0,1'b1, 5'd9,1'b0,32'h99,      32'h200);
    // vt[9]: reg 9 is still reserved from vt[6], so stall with r1=r2=0 is 0.
    vt[9].e_st = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive_ab(vt[i].av, vt[i].ar, vt[i].ad, vt[i].bv, vt[i].br, vt[i].bd);
      rsv_valid = vt[i].rv; rsv_reg = vt[i].rr;
      read_reg1 = vt[i].r1; read_reg2 = vt[i].r2;
      @(negedge clk);
      check($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vt[i].e_ar});
      check($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vt[i].e_br});
      check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].e_st});
      @(posedge clk); #1;
      check($sformatf("v%0d_write_reg", i), {27'd0, write_reg}, {27'd0, vt[i].e_wr});
      check($sformatf("v%0d_flag", i), {31'd0, reg_write_flag}, {31'd0, vt[i].e_fl});
      check($sformatf("v%0d_data", i), data, vt[i].e_d);
      check($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
    end

    // Contention right after reset: grants A,B,A,B and back-to-back pulses.
    do_reset();
    exp_wr[0] = 5'd1; exp_wr[1] = 5'd2; exp_wr[2] = 5'd3; exp_wr[3] = 5'd4;
    drive_ab(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
    @(negedge clk);
    check("rr0_a_ready", {31'd0, a_ready}, 32'd1);
    check("rr0_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    check("rr0_wr", {27'd0, write_reg}, {27'd0, exp_wr[0]});
    check("rr0_flag", {31'd0, reg_write_flag}, 32'd1);
    drive_ab(1'b1, 5'd3, 32'hA3, 1'b1, 5'd2, 32'hB2);
    @(negedge clk);
    check("rr1_b_ready", {31'd0, b_ready}, 32'd1);
    check("rr1_a_ready", {31'd0, a_ready}, 32'd0);
    @(posedge clk); #1;
    check("rr1_wr", {27'd0, write_reg}, {27'd0, exp_wr[1]});
    check("rr1_flag", {31'd0, reg_write_flag}, 32'd1);
    check("rr1_data", data, 32'hB2);
    drive_ab(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4);
    @(negedge clk);
    check("rr2_a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk); #1;
    check("rr2_wr", {27'd0, write_reg}, {27'd0, exp_wr[2]});
    check("rr2_flag", {31'd0, reg_write_flag}, 32'd1);
    drive_ab(1'b1, 5'd5, 32'hA5, 1'b1, 5'd4, 32'hB4);
    @(negedge clk);
    check("rr3_b_ready", {31'd0, b_ready}, 32'd1);
    @(posedge clk); #1;
    check("rr3_wr", {27'd0, write_reg}, {27'd0, exp_wr[3]});
    check("rr3_flag", {31'd0, reg_write_flag}, 32'd1);

    // Reset mid-stream with busy = 0x84 and a transfer at the reset edge.
    do_reset();
    rsv_valid = 1'b1; rsv_reg = 5'd2;
    @(posedge clk); #1;
    rsv_reg = 5'd7;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    check("mid_busy_before", busy, 32'h84);
    rst = 1'b1;
    drive_ab(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0);
    rsv_valid = 1'b1; rsv_reg = 5'd5;
    @(posedge clk); #1;
    rst = 1'b0; rsv_valid = 1'b0;
    check("mid_busy_after", busy, 32'h0);
    check("mid_flag_after", {31'd0, reg_write_flag}, 32'd0);
    check("mid_wr_after", {27'd0, write_reg}, 32'd0);
    check("mid_data_after", data, 32'd0);
    drive_ab(1'b1, 5'd8, 32'h8888, 1'b1, 5'd9, 32'h9999);
    @(negedge clk);
    check("mid_ptr_a_ready", {31'd0, a_ready}, 32'd1);
    check("mid_ptr_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    check("mid_post_wr", {27'd0, write_reg}, 32'd8);
    check("mid_post_flag", {31'd0, reg_write_flag}, 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    a_pend = 1'b0; b_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!a_pend) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_reg = 5'($urandom_range(0, 15));
        a_data = $urandom;
      end
      if (!b_pend) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_reg = 5'($urandom_range(0, 15));
        b_data = $urandom;
      end
      rsv_valid = ($urandom_range(0, 1) != 0);
      rsv_reg = 5'($urandom_range(0, 15));
      read_reg1 = 5'($urandom_range(0, 15));
      read_reg2 = 5'($urandom_range(0, 15));
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      model_grant(ga, gb);
      mst = m_busy[read_reg1] || m_busy[read_reg2];
      check("rnd_a_ready", {31'd0, a_ready}, {31'd0, ga});
      check("rnd_b_ready", {31'd0, b_ready}, {31'd0, gb});
      check("rnd_stall", {31'd0, stall}, {31'd0, mst});
      // A request stays pending (same reg/data) until it is granted.
      a_pend = a_valid && !ga;
      b_pend = b_valid && !gb;
      model_edge();
      @(posedge clk); #1;
      check("rnd_flag", {31'd0, reg_write_flag}, {31'd0, m_flag});
      check("rnd_wr", {27'd0, write_reg}, {27'd0, m_wr});
      check("rnd_data", data, m_data);
      check("rnd_busy", busy, m_busy_vec());
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
